load_ext_stage: RTL and testbench

LOAD_EXT_STAGE -- requirements
Module: load_ext_stage

---
 rtl/load_ext_stage_if.sv | 31 +++
 rtl/load_ext_stage.sv | 145 ++++++++++++++
 tb/tb_load_ext_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_ext_stage_if.sv
// Handshake bundle for load_ext_stage: one input beat channel and one result channel.
interface load_ext_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    logic              in_sext;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_off, in_size, in_sext, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_off, in_size, in_sext, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/load_ext_stage.sv
// Load data extractor/extender with a one-cycle main+skid output buffer.
// Optional misalignment check enabled by defining LOAD_EXT_MISALIGN_CHK_EN.
module load_ext_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    load_ext_stage_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;

    logic [1:0]        size_eff;
    logic [OFF_W-1:0]  size_mask;
    logic [OFF_W-1:0]  off_al;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] field_mask;
    logic [DATA_W-1:0] ext;
    logic              sign_bit;
    beat_t             new_beat;
    logic              in_fire;
    logic              out_fire;

    // Field extraction: align offset down to the access size, shift, mask, extend.
    always_comb begin
        size_eff = bus.in_size;
        if (DATA_W == 32 && bus.in_size == 2'b11) begin
            size_eff = 2'b10;
        end
        size_mask = OFF_W'((4'd1 << size_eff) - 4'd1);
        off_al    = bus.in_off & ~size_mask;
        shifted   = bus.in_data >> {off_al, 3'b000};

        field_mask = '1;
        sign_bit   = 1'b0;
        case (size_eff)
            2'b00: begin
                field_mask = DATA_W'(8'hFF);
                sign_bit   = shifted[7];
            end
            2'b01: begin
                field_mask = DATA_W'(16'hFFFF);
                sign_bit   = shifted[15];
            end
            2'b10: begin
                field_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit   = shifted[31];
            end
            default: begin
                field_mask = '1;
                sign_bit   = 1'b0;
            end
        endcase

        ext = (shifted & field_mask) | ((bus.in_sext && sign_bit) ? ~field_mask : '0);

        new_beat.tag = bus.in_tag;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        new_beat.err  = |(bus.in_off & size_mask);
        new_beat.data = new_beat.err ? '0 : ext;
`else
        new_beat.err  = 1'b0;
        new_beat.data = ext;
`endif
    end

    // Buffer control: main register feeds the output, skid absorbs one stalled beat.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        in_fire  = bus.in_valid && in_ready_q;
        out_fire = out_valid_q && bus.out_ready;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = new_beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = new_beat;
                end else if (in_fire) begin
                    skid_d  = new_beat;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q.data;
    assign bus.out_tag   = main_q.tag;
    assign bus.out_err   = main_q.err;
endmodule

// File: tb/tb_load_ext_stage.sv
// Bench for load_ext_stage: 32-bit instance checked by a scoreboard model every cycle,
// 64-bit instance checked with directed literals including reset while two beats are held.
module tb_load_ext_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst64 = 1'b0;
    always #5 clk = ~clk;

    load_ext_stage_if #(.DATA_W(32), .TAG_W(5)) bus32();
    load_ext_stage_if #(.DATA_W(64), .TAG_W(5)) bus64();

    load_ext_stage #(.DATA_W(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst),   .bus(bus32.slave));
    load_ext_stage #(.DATA_W(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst64), .bus(bus64.slave));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the addressed bytes one by one, then fill upper bits by sign or zero.
    function automatic logic [64:0] model(input int dw, input logic [63:0] d, input int off,
                                          input int size, input bit sext);
        int sz;
        int nb;
        int o;
        logic [63:0] r;
        sz = size;
        if (dw == 32 && sz == 3) sz = 2;
        nb = 1 << sz;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        if ((off % nb) != 0) return {1'b1, 64'd0};
`endif
        o = off - (off % nb);
        r = '0;
        for (int i = 0; i < 8 * nb; i++) r[i] = d[8 * o + i];
        if (sext && r[8 * nb - 1]) begin
            for (int i = 8 * nb; i < dw; i++) r[i] = 1'b1;
        end
        return {1'b0, r};
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_out = 0;
    bit   armed = 0;

    // Scoreboard for the 32-bit instance: compare current outputs, then predict the next edge.
    always @(negedge clk) begin
        logic [64:0] m;
        exp_t e;
        if (rst) begin
            q.delete();
            armed = 0;
        end else begin
            chk("in_ready", 64'(bus32.in_ready), 64'(armed && q.size() < 2));
            chk("out_valid", 64'(bus32.out_valid), 64'(q.size() != 0));
            if (bus32.out_valid && q.size() != 0) begin
                chk("out_data", 64'(bus32.out_data), 64'(q[0].data));
                chk("out_tag", 64'(bus32.out_tag), 64'(q[0].tag));
                chk("out_err", 64'(bus32.out_err), 64'(q[0].err));
            end
            if (bus32.out_valid && bus32.out_ready && q.size() != 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (bus32.in_valid && bus32.in_ready) begin
                m = model(32, {32'd0, bus32.in_data}, int'(bus32.in_off), int'(bus32.in_size),
                          bus32.in_sext);
                e.data = m[31:0];
                e.err  = m[64];
                e.tag  = bus32.in_tag;
                q.push_back(e);
            end
            armed = 1;
        end
    end

    // out_ready driver for the 32-bit instance: 0 low, 1 high, 2 fixed toggle pattern.
    int         rdy_mode = 0;
    int         cyc = 0;
    logic [7:0] rdy_pat = 8'b1011_0110;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus32.out_ready = 1'b0;
            1:       bus32.out_ready = 1'b1;
            default: bus32.out_ready = rdy_pat[cyc % 8];
        endcase
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                          input bit sx, input logic [4:0] tg);
        bus32.in_valid = 1'b1;
        bus32.in_data  = d;
        bus32.in_off   = off;
        bus32.in_size  = sz;
        bus32.in_sext  = sx;
        bus32.in_tag   = tg;
        for (int i = 0; i < 50 && !bus32.in_ready; i++) tick();
        if (!bus32.in_ready) chk("send32_accept", 64'(bus32.in_ready), 64'd1);
        tick();
        bus32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                          input bit sx, input logic [4:0] tg);
        bus64.in_valid = 1'b1;
        bus64.in_data  = d;
        bus64.in_off   = off;
        bus64.in_size  = sz;
        bus64.in_sext  = sx;
        bus64.in_tag   = tg;
        for (int i = 0; i < 50 && !bus64.in_ready; i++) tick();
        if (!bus64.in_ready) chk("send64_accept", 64'(bus64.in_ready), 64'd1);
        tick();
        bus64.in_valid = 1'b0;
    endtask

    // One beat with out_ready high; the result must be present right after the accepting edge.
    task automatic lit32(input string name, input logic [31:0] d, input logic [1:0] off,
                         input logic [1:0] sz, input bit sx, input logic [31:0] expd,
                         input bit experr);
        send32(d, off, sz, sx, 5'd9);
        chk({name, "_valid"}, 64'(bus32.out_valid), 64'd1);
        chk({name, "_data"}, 64'(bus32.out_data), 64'(expd));
        chk({name, "_err"}, 64'(bus32.out_err), 64'(experr));
        tick();
    endtask

    int base;

    initial begin
        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_off = '0;
        bus32.in_size = '0; bus32.in_sext = 1'b0; bus32.in_tag = '0;
        bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_off = '0;
        bus64.in_size = '0; bus64.in_sext = 1'b0; bus64.in_tag = '0;
        bus64.out_ready = 1'b0;
        #1;
        rst = 1'b1;
        rst64 = 1'b1;
        tick();
        tick();

        chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus32.in_ready), 64'd0);
        chk("rst_out_data", 64'(bus32.out_data), 64'd0);
        chk("rst_out_tag", 64'(bus32.out_tag), 64'd0);
        chk("rst_out_err", 64'(bus32.out_err), 64'd0);
        chk("rst64_out_valid", 64'(bus64.out_valid), 64'd0);
        chk("rst64_in_ready", 64'(bus64.in_ready), 64'd0);

        rst = 1'b0;
        rst64 = 1'b0;
        #1;
        chk("pre_edge_in_ready", 64'(bus32.in_ready), 64'd0);
        tick();
        chk("first_edge_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("first_edge_in_ready64", 64'(bus64.in_ready), 64'd1);

        rdy_mode = 1;
        tick();
        lit32("byte_sext", 32'h1234_80FF, 2'd1, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0);
        lit32("byte_zext", 32'h1234_80FF, 2'd1, 2'b00, 1'b0, 32'h0000_0080, 1'b0);
        lit32("half_sext", 32'h8001_0000, 2'd2, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0);
        lit32("dword_as_word", 32'h8765_4321, 2'd0, 2'b11, 1'b1, 32'h8765_4321, 1'b0);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        lit32("misalign_word", 32'hDEAD_BEEF, 2'd2, 2'b10, 1'b1, 32'h0000_0000, 1'b1);
`else
        lit32("misalign_word", 32'hDEAD_BEEF, 2'd2, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0);
`endif

        // Backpressure: three beats against a stalled consumer.
        rdy_mode = 0;
        tick();
        tick();
        base = n_out;
        send32(32'h0000_00A1, 2'd0, 2'b00, 1'b0, 5'd1);
        send32(32'h0000_B200, 2'd1, 2'b00, 1'b1, 5'd2);
        chk("bp_in_ready_after_2nd", 64'(bus32.in_ready), 64'd0);
        bus32.in_valid = 1'b1;
        bus32.in_data  = 32'hC3C3_0000;
        bus32.in_off   = 2'd2;
        bus32.in_size  = 2'b01;
        bus32.in_sext  = 1'b1;
        bus32.in_tag   = 5'd3;
        tick();
        tick();
        chk("bp_in_ready_held", 64'(bus32.in_ready), 64'd0);
        rdy_mode = 1;
        send32(32'hC3C3_0000, 2'd2, 2'b01, 1'b1, 5'd3);
        for (int i = 0; i < 6; i++) tick();
        chk("bp_out_count", 64'(n_out - base), 64'd3);

        // Sweep of sizes, offsets and extension modes under a toggling consumer.
        rdy_mode = 2;
        for (int sz = 0; sz < 4; sz++) begin
            for (int off = 0; off < 4; off++) begin
                for (int sx = 0; sx < 2; sx++) begin
                    send32(32'h80F1_7E02 ^ (32'h1111_1111 * 32'(off)), 2'(off), 2'(sz), sx[0],
                           5'(sz * 8 + off * 2 + sx));
                end
            end
        end
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("sweep_drained", 64'(q.size()), 64'd0);

        // 64-bit instance.
        bus64.out_ready = 1'b1;
        send64(64'h8000_0000_0000_0000, 3'd4, 2'b10, 1'b1, 5'd7);
        chk("w64_valid", 64'(bus64.out_valid), 64'd1);
        chk("w64_data", bus64.out_data, 64'hFFFF_FFFF_8000_0000);
        chk("w64_tag", 64'(bus64.out_tag), 64'd7);
        tick();
        send64(64'h8123_4567_89AB_CDEF, 3'd0, 2'b11, 1'b1, 5'd8);
        chk("dw64_data", bus64.out_data, 64'h8123_4567_89AB_CDEF);
        tick();

        bus64.out_ready = 1'b0;
        tick();
        send64(64'h0000_0000_0000_00AA, 3'd0, 2'b00, 1'b0, 5'd10);
        send64(64'h0000_0000_0000_BB00, 3'd1, 2'b00, 1'b0, 5'd11);
        chk("two64_in_ready", 64'(bus64.in_ready), 64'd0);
        chk("two64_out_valid", 64'(bus64.out_valid), 64'd1);
        #2;
        rst64 = 1'b1;
        #1;
        chk("rst_two64_out_valid", 64'(bus64.out_valid), 64'd0);
        chk("rst_two64_in_ready", 64'(bus64.in_ready), 64'd0);
        chk("rst_two64_out_data", bus64.out_data, 64'd0);
        tick();
        rst64 = 1'b0;
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst64_no_emit", 64'(bus64.out_valid), 64'd0);
        end
        chk("post_rst64_in_ready", 64'(bus64.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
